// File: rtl/row_packer96.sv
// Packs twelve consecutive element bytes into a staged 96-bit row and hands it
// to the downstream operand register with a one-cycle ld strobe.
module row_packer96 #(
   parameter int ROWS  = 3,
   parameter int ROW_W = 2
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [7:0]       din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             out_ready,
   output logic             ld,
   output logic [7:0]       Dout1,
   output logic [7:0]       Dout2,
   output logic [7:0]       Dout3,
   output logic [7:0]       Dout4,
   output logic [7:0]       Dout5,
   output logic [7:0]       Dout6,
   output logic [7:0]       Dout7,
   output logic [7:0]       Dout8,
   output logic [7:0]       Dout9,
   output logic [7:0]       Dout10,
   output logic [7:0]       Dout11,
   output logic [7:0]       Dout12,
   output logic [ROW_W-1:0] row_idx,
   output logic             frame_done,
   output logic             busy,
   output logic             dbg_state
);

   typedef enum logic {FILL = 1'b0, LOAD = 1'b1} state_t;

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] slot [12];
   logic       take;

   // Handshakes: a byte moves when din_valid && din_ready are both high at a
   // rising edge; a row moves when ld (LOAD && out_ready) is high at an edge.
   // din_ready never looks at din_valid, so there is no valid->ready path.
   assign din_ready  = (state == FILL);
   assign ld         = (state == LOAD) && out_ready;
   assign frame_done = ld && (row_idx == LAST_ROW);
   assign busy       = (cnt != 4'd0) || (state == LOAD);
   assign dbg_state  = state;
   assign take       = din_valid && din_ready;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state   <= FILL;
         cnt     <= 4'd0;
         row_idx <= '0;
         for (int k = 0; k < 12; k++) slot[k] <= 8'h00;
      end else begin
         case (state)
            FILL: begin
               if (take) begin
                  slot[cnt] <= din;
                  if (cnt == 4'd11) begin
                     cnt   <= 4'd0;
                     state <= LOAD;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            LOAD: begin
               // Row stays staged until the downstream register takes it.
               if (out_ready) begin
                  state   <= FILL;
                  row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + ROW_W'(1);
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign Dout1  = slot[0];
   assign Dout2  = slot[1];
   assign Dout3  = slot[2];
   assign Dout4  = slot[3];
   assign Dout5  = slot[4];
   assign Dout6  = slot[5];
   assign Dout7  = slot[6];
   assign Dout8  = slot[7];
   assign Dout9  = slot[8];
   assign Dout10 = slot[9];
   assign Dout11 = slot[10];
   assign Dout12 = slot[11];

endmodule

// File: tb/tb_row_packer96.sv
// Directed bench for row_packer96: rows are queued as expected values when
// driven and compared against the DUT outputs whenever ld fires.
module tb_row_packer96;

   localparam int ROWS  = 3;
   localparam int ROW_W = 2;

   logic             CLK;
   logic             reset;
   logic [7:0]       din;
   logic             din_valid;
   logic             din_ready;
   logic             out_ready;
   logic             ld;
   logic [7:0]       Dout1, Dout2, Dout3, Dout4, Dout5, Dout6;
   logic [7:0]       Dout7, Dout8, Dout9, Dout10, Dout11, Dout12;
   logic [ROW_W-1:0] row_idx;
   logic             frame_done;
   logic             busy;
   logic             dbg_state;
   logic [95:0]      dout_vec;

   row_packer96 #(.ROWS(ROWS), .ROW_W(ROW_W)) dut (
      .CLK(CLK), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .out_ready(out_ready), .ld(ld),
      .Dout1(Dout1), .Dout2(Dout2), .Dout3(Dout3), .Dout4(Dout4),
      .Dout5(Dout5), .Dout6(Dout6), .Dout7(Dout7), .Dout8(Dout8),
      .Dout9(Dout9), .Dout10(Dout10), .Dout11(Dout11), .Dout12(Dout12),
      .row_idx(row_idx), .frame_done(frame_done), .busy(busy),
      .dbg_state(dbg_state)
   );

   // byte k (arrival order) lives at dout_vec[8k +: 8]
   assign dout_vec = {Dout12, Dout11, Dout10, Dout9, Dout8, Dout7,
                      Dout6, Dout5, Dout4, Dout3, Dout2, Dout1};

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // scoreboard state
   logic [95:0]      exp_q[$];
   logic [ROW_W-1:0] idx_q[$];
   logic             fd_q[$];
   int               ld_cyc_q[$];
   int               exp_idx = 0;
   int               checks = 0;
   int               failures = 0;
   int               ld_cnt = 0;
   int               nready_cnt = 0;
   int               acc_cyc = 0;
   int               first_acc = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (!din_ready) nready_cnt++;
      if (!reset && ld) begin
         ld_cnt++;
         ld_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_ld observed=ld expected=no_ld row=%0h", dout_vec);
         end else begin
            check("ld_row_data", dout_vec, exp_q.pop_front());
            check("ld_row_idx", 96'(row_idx), 96'(idx_q.pop_front()));
            check("ld_frame_done", 96'(frame_done), 96'(fd_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic do_reset();
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      exp_idx = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited;
      bit rdy;
      din = b;
      din_valid = 1'b1;
      waited = 0;
      rdy = 1'b0;
      while (!rdy && waited < 200) begin
         @(negedge CLK);
         rdy = din_ready;
         @(posedge CLK); #1;
         waited++;
      end
      din_valid = 1'b0;
      if (!rdy) begin
         checks++;
         failures++;
         $error("FAIL send_timeout observed=stalled expected=accepted byte=%0h", b);
      end else begin
         acc_cyc = cyc;
      end
   endtask

   task automatic send_row(input logic [7:0] base, input bit push, input int gap);
      logic [95:0] row;
      logic [7:0]  b;
      for (int k = 0; k < 12; k++) begin
         b = base + 8'(k);
         row[8*k +: 8] = b;
      end
      if (push) begin
         exp_q.push_back(row);
         idx_q.push_back(ROW_W'(exp_idx));
         fd_q.push_back(exp_idx == ROWS - 1);
         exp_idx = (exp_idx == ROWS - 1) ? 0 : exp_idx + 1;
      end
      for (int k = 0; k < 12; k++) begin
         send_byte(row[8*k +: 8]);
         if (k == 0) first_acc = acc_cyc;
         if (k != 11) repeat (gap) begin @(posedge CLK); #1; end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   // directed sequence
   initial begin
      int snap;
      logic [95:0] row3;
      reset = 1'b1;
      din = 8'h00;
      din_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      reset = 1'b0;

      // reset state
      @(negedge CLK);
      check("rst_din_ready", 96'(din_ready), 96'(1));
      check("rst_ld", 96'(ld), 96'(0));
      check("rst_busy", 96'(busy), 96'(0));
      check("rst_frame_done", 96'(frame_done), 96'(0));
      check("rst_row_idx", 96'(row_idx), 96'(0));
      check("rst_dout", dout_vec, 96'h0);
      @(posedge CLK); #1;

      // back-to-back single row
      out_ready = 1'b1;
      ld_cyc_q.delete();
      send_row(8'h01, 1'b1, 0);
      idle(3);
      check("t1_ld_count", 96'(ld_cnt), 96'(1));
      if (ld_cyc_q.size() > 0) begin
         check("t1_ld_after_12th", 96'(ld_cyc_q[0]), 96'(acc_cyc));
         check("t1_ld_latency", 96'(ld_cyc_q[0] - first_acc), 96'(11));
      end
      check("t1_row_idx_after", 96'(row_idx), 96'(1));

      // three-row frame streamed continuously
      do_reset();
      ld_cyc_q.delete();
      snap = nready_cnt;
      send_row(8'h01, 1'b1, 0);
      send_row(8'h0D, 1'b1, 0);
      send_row(8'h19, 1'b1, 0);
      idle(3);
      check("t2_ld_pulses", 96'(ld_cyc_q.size()), 96'(3));
      if (ld_cyc_q.size() == 3) begin
         check("t2_gap_1", 96'(ld_cyc_q[1] - ld_cyc_q[0]), 96'(13));
         check("t2_gap_2", 96'(ld_cyc_q[2] - ld_cyc_q[1]), 96'(13));
      end
      check("t2_not_ready_cycles", 96'(nready_cnt - snap), 96'(3));
      check("t2_row_idx_wrap", 96'(row_idx), 96'(0));

      // downstream stall in LOAD
      out_ready = 1'b0;
      send_row(8'h41, 1'b1, 0);
      for (int k = 0; k < 12; k++) row3[8*k +: 8] = 8'h41 + 8'(k);
      din = 8'hFF;
      din_valid = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         check("t3_stall_ld", 96'(ld), 96'(0));
         check("t3_stall_din_ready", 96'(din_ready), 96'(0));
         check("t3_stall_dout", dout_vec, row3);
         @(posedge CLK); #1;
      end
      din_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge CLK);
      check("t3_release_ld", 96'(ld), 96'(1));
      @(posedge CLK); #1;
      @(negedge CLK);
      check("t3_after_ld", 96'(ld), 96'(0));
      check("t3_after_din_ready", 96'(din_ready), 96'(1));
      check("t3_ff_not_taken", 96'(busy), 96'(0));
      @(posedge CLK); #1;

      // valid only every third cycle
      ld_cyc_q.delete();
      send_row(8'h01, 1'b1, 2);
      idle(3);
      check("t4_ld_pulses", 96'(ld_cyc_q.size()), 96'(1));
      if (ld_cyc_q.size() > 0)
         check("t4_ld_after_12th", 96'(ld_cyc_q[0]), 96'(acc_cyc));

      // reset mid-row
      for (int k = 0; k < 7; k++) send_byte(8'h50 + 8'(k));
      @(negedge CLK);
      check("t5_busy_mid_row", 96'(busy), 96'(1));
      @(posedge CLK); #1;
      do_reset();
      @(negedge CLK);
      check("t5_dout_cleared", dout_vec, 96'h0);
      check("t5_busy", 96'(busy), 96'(0));
      check("t5_row_idx", 96'(row_idx), 96'(0));
      @(posedge CLK); #1;
      exp_q.push_back(96'h2C2B2A29_28272625_24232221);
      idx_q.push_back(ROW_W'(0));
      fd_q.push_back(1'b0);
      exp_idx = 1;
      for (int k = 0; k < 3; k++) send_byte(8'h21 + 8'(k));
      @(negedge CLK);
      check("t5_partial_slots", dout_vec, 96'h00000000_00000000_00232221);
      @(posedge CLK); #1;
      for (int k = 3; k < 12; k++) send_byte(8'h21 + 8'(k));
      idle(3);

      // reset while stalled in LOAD
      out_ready = 1'b0;
      snap = ld_cnt;
      send_row(8'h31, 1'b0, 0);
      @(negedge CLK);
      check("t6_in_load_ready", 96'(din_ready), 96'(0));
      @(posedge CLK); #1;
      do_reset();
      @(negedge CLK);
      check("t6_ready_after_reset", 96'(din_ready), 96'(1));
      check("t6_busy_after_reset", 96'(busy), 96'(0));
      @(posedge CLK); #1;
      out_ready = 1'b1;
      idle(5);
      check("t6_no_ld", 96'(ld_cnt - snap), 96'(0));

      check("sb_drained", 96'(exp_q.size()), 96'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
